// File: rtl/pll_mode_sequencer.sv
// PLL mode bring-up: reset pulse, lock wait, settle window, bounded retries, sticky failure.
// Build macro PLL_LOCK_MONITOR_EN adds re-sequencing when lock drops while idle and settled.
module pll_mode_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_req_valid,
    input  logic [7:0] mode_req_data,
    output logic       mode_req_ready,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic [7:0] pll_data,
    output logic [7:0] mode_active,
    output logic       video_ok,
    output logic       error,
    output logic       lock_lost
);

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [15:0]   TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TRY_MAX  = TW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic [15:0]   tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0] retry_q, retry_d;
    logic          pll_reset_q, pll_reset_d;
    logic [7:0]    pll_data_q, pll_data_d;
    logic [7:0]    mode_active_q, mode_active_d;
    logic          video_ok_q, video_ok_d;
    logic          error_q, error_d;
    logic          lock_lost_q, lock_lost_d;
    logic          sync1_q, sync2_q;

    logic          locked_s;
    logic          mon_fire;
    logic          accept;
    logic          timed_out;
    logic [15:0]   tmo_inc;
    logic [TW-1:0] retry_inc;

    assign locked_s = sync2_q;

`ifdef PLL_LOCK_MONITOR_EN
    assign mon_fire = (state_q == ST_IDLE) && video_ok_q && !locked_s;
`else
    assign mon_fire = 1'b0;
`endif

    // Ready is withheld when the lock monitor fires so a request is never silently dropped.
    assign mode_req_ready = !reset && !mon_fire &&
                            ((state_q == ST_IDLE) || (state_q == ST_FAIL));
    assign accept         = mode_req_valid && mode_req_ready;

    assign tmo_inc   = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    assign retry_inc = (retry_q == TRY_MAX) ? retry_q : retry_q + TW'(1);

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        set_cnt_d     = set_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        retry_d       = retry_q;
        pll_reset_d   = pll_reset_q;
        pll_data_d    = pll_data_q;
        mode_active_d = mode_active_q;
        video_ok_d    = video_ok_q;
        error_d       = error_q;
        lock_lost_d   = 1'b0;
        timed_out     = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (mon_fire) begin
                    lock_lost_d = 1'b1;
                    video_ok_d  = 1'b0;
                    retry_d     = '0;
                    rst_cnt_d   = '0;
                    pll_reset_d = 1'b1;
                    state_d     = ST_RESET_PLL;
                end else if (accept) begin
                    pll_data_d  = mode_req_data;
                    retry_d     = '0;
                    video_ok_d  = 1'b0;
                    error_d     = 1'b0;
                    rst_cnt_d   = '0;
                    pll_reset_d = 1'b1;
                    state_d     = ST_RESET_PLL;
                end
            end
            ST_RESET_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    pll_reset_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_cnt_q == TMO_LAST) begin
                    timed_out = 1'b1;
                end else if (locked_s) begin
                    set_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmo_cnt_d = tmo_inc;
                // A settle completing on the final allowed cycle wins over the timeout.
                if (locked_s && (set_cnt_q == SET_LAST)) begin
                    video_ok_d    = 1'b1;
                    mode_active_d = pll_data_q;
                    state_d       = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timed_out = 1'b1;
                end else if (!locked_s) begin
                    set_cnt_d = '0;
                    state_d   = ST_WAIT_LOCK;
                end else begin
                    set_cnt_d = set_cnt_q + SW'(1);
                end
            end
            default: begin
                rst_cnt_d   = '0;
                pll_reset_d = 1'b1;
                state_d     = ST_RESET_PLL;
            end
        endcase

        if (timed_out) begin
            retry_d     = retry_inc;
            pll_reset_d = 1'b1;
            if (retry_inc < TRY_MAX) begin
                rst_cnt_d = '0;
                state_d   = ST_RESET_PLL;
            end else begin
                error_d    = 1'b1;
                video_ok_d = 1'b0;
                state_d    = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            state_q       <= ST_RESET_PLL;
            rst_cnt_q     <= '0;
            set_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            retry_q       <= '0;
            pll_reset_q   <= 1'b1;
            pll_data_q    <= 8'd0;
            mode_active_q <= 8'd0;
            video_ok_q    <= 1'b0;
            error_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            sync1_q       <= pll_locked;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            set_cnt_q     <= set_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            retry_q       <= retry_d;
            pll_reset_q   <= pll_reset_d;
            pll_data_q    <= pll_data_d;
            mode_active_q <= mode_active_d;
            video_ok_q    <= video_ok_d;
            error_q       <= error_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign pll_data    = pll_data_q;
    assign mode_active = mode_active_q;
    assign video_ok    = video_ok_q;
    assign error       = error_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Bench for pll_mode_sequencer: per-cycle comparison against a timestamp-based attempt model.
module tb_pll_mode_sequencer;

    localparam int R  = 4;
    localparam int S  = 8;
    localparam int LT = 32;
    localparam int MR = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode_req_valid = 1'b0;
    logic [7:0] mode_req_data = 8'd0;
    logic       pll_locked = 1'b0;
    logic       mode_req_ready;
    logic       pll_reset;
    logic [7:0] pll_data;
    logic [7:0] mode_active;
    logic       video_ok;
    logic       error;
    logic       lock_lost;

    pll_mode_sequencer #(
        .RESET_CYCLES (R),
        .SETTLE_CYCLES(S),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode_req_valid(mode_req_valid),
        .mode_req_data (mode_req_data),
        .mode_req_ready(mode_req_ready),
        .pll_locked    (pll_locked),
        .pll_reset     (pll_reset),
        .pll_data      (pll_data),
        .mode_active   (mode_active),
        .video_ok      (video_ok),
        .error         (error),
        .lock_lost     (lock_lost)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    // Synchronised lock as the design should see it: hist[k] is pll_locked captured at edge k.
    logic hist [0:16383];

    // Reference: an attempt starts at edge m_k0, holds PLL reset R cycles, then has LT cycles
    // to observe S+1 consecutive synchronised-lock cycles before the attempt is charged.
    bit         m_busy = 1'b0, m_fail = 1'b0, m_video = 1'b0, m_lost = 1'b0;
    int         m_k0 = 0, m_tries = 0, m_run = 0;
    logic [7:0] m_data = 8'd0, m_active = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit lk,
                        output bit acc);
        bit mon;
        bit e_ready;
        @(negedge clock);
        reset = r;
        mode_req_valid = v;
        mode_req_data = d;
        pll_locked = lk;
        #1;
        mon = 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
        mon = started && !m_busy && !m_fail && m_video && !hist[cyc-1];
`endif
        e_ready = !r && !m_busy && !mon;
        if (started) begin
            chk("ready",       mode_req_ready, e_ready);
            chk("pll_reset",   pll_reset,      m_fail || (m_busy && cyc < m_k0 + R));
            chk("video_ok",    video_ok,       m_video);
            chk("error",       error,          m_fail);
            chk("mode_active", mode_active,    m_active);
            chk("pll_data",    pll_data,       m_data);
            chk("lock_lost",   lock_lost,      m_lost);
        end
        acc = v && e_ready;
        @(posedge clock);
        cyc++;
        if (r) begin
            hist[cyc] = 1'b0;
            started   = 1'b1;
            m_busy = 1'b1; m_fail = 1'b0; m_video = 1'b0; m_lost = 1'b0;
            m_k0 = cyc; m_tries = 0; m_run = 0; m_data = 8'd0; m_active = 8'd0;
        end else begin
            hist[cyc] = lk;
            m_lost = 1'b0;
            if (m_busy) begin
                if (cyc - 1 >= m_k0 + R) begin
                    m_run = hist[cyc-2] ? m_run + 1 : 0;
                    if (m_run == S + 1) begin
                        m_busy = 1'b0; m_video = 1'b1; m_active = m_data;
                    end else if (cyc - 1 == m_k0 + R + LT - 1) begin
                        m_tries++;
                        if (m_tries < MR) begin
                            m_k0 = cyc; m_run = 0;
                        end else begin
                            m_busy = 1'b0; m_fail = 1'b1;
                        end
                    end
                end
            end else if (mon) begin
                m_lost = 1'b1; m_video = 1'b0; m_busy = 1'b1;
                m_k0 = cyc; m_tries = 0; m_run = 0;
            end else if (acc) begin
                m_data = d; m_tries = 0; m_video = 1'b0; m_fail = 1'b0;
                m_busy = 1'b1; m_k0 = cyc; m_run = 0;
            end
        end
    endtask

    task automatic idle(input int n, input bit lk);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, lk, acc);
    endtask

    task automatic req(input logic [7:0] d, input bit lk);
        bit acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) step(1'b0, 1'b1, d, lk, acc);
        chk("accept", acc, 1);
    endtask

    initial begin
        bit acc;
        int lk_mode = 0, lk_left = 0, rst_left = 0;
        bit req_pend = 1'b0;
        logic [7:0] req_dat = 8'd0;
        bit lk, r;

        // Power-up sequence for mode 0x00 with the PLL locking immediately.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, 1'b1, acc);
        idle(30, 1'b1);
        #2;
        chk("init_video", video_ok, 1);
        chk("init_mode", mode_active, 8'h00);
        chk("init_ready", mode_req_ready, 1);

        req(8'h5A, 1'b1);
        #2;
        chk("ready_drop", mode_req_ready, 0);
        chk("pll_data_5a", pll_data, 8'h5A);
        chk("pll_reset_5a", pll_reset, 1);
        idle(26, 1'b1);
        #2;
        chk("video_5a", video_ok, 1);
        chk("mode_5a", mode_active, 8'h5A);

        // No lock at all: two attempts of R + LT cycles, then FAIL.
        req(8'h33, 1'b0);
        idle(2 * (R + LT) + 5, 1'b0);
        #2;
        chk("fail_error", error, 1);
        chk("fail_ready", mode_req_ready, 1);
        chk("fail_video", video_ok, 0);
        chk("fail_data_kept", pll_data, 8'h33);
        req(8'h11, 1'b1);
        idle(1, 1'b1);
        #2;
        chk("error_cleared", error, 0);
        idle(25, 1'b1);
        #2;
        chk("mode_11", mode_active, 8'h11);

        // One-cycle lock glitch landing at settle count 5.
        req(8'h77, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b0, 8'd0, (i != 9), acc);
            if (i == 19) begin #2; chk("glitch_not_yet", video_ok, 0); end
            if (i == 20) begin #2; chk("glitch_settled", video_ok, 1); end
        end

        // Lock loss while idle and settled.
        idle(4, 1'b0);
        idle(30, 1'b1);
        #2;
        chk("relock_video", video_ok, 1);
        chk("relock_mode", mode_active, 8'h77);

        // Reset in the middle of a sequence restarts mode 0x00.
        req(8'h44, 1'b1);
        idle(6, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'd0, 1'b1, acc);
        idle(30, 1'b1);
        #2;
        chk("rst_mid_data", pll_data, 8'h00);
        chk("rst_mid_mode", mode_active, 8'h00);
        chk("rst_mid_video", video_ok, 1);

        for (int i = 0; i < 4000; i++) begin
            if (lk_left == 0) begin
                lk_mode = $urandom_range(0, 3);
                lk_left = $urandom_range(5, 120);
            end
            lk_left--;
            case (lk_mode)
                0:       lk = 1'b1;
                1:       lk = 1'b0;
                2:       lk = ($urandom_range(0, 15) != 0);
                default: lk = ($urandom_range(0, 1) == 1);
            endcase
            if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
            r = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            if (!req_pend && $urandom_range(0, 39) == 0) begin
                req_pend = 1'b1;
                req_dat  = 8'($urandom);
            end
            step(r, req_pend, req_dat, lk, acc);
            if (acc) req_pend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_mode_sequencer.md
PLL_MODE_SEQUENCER -- requirements
Module: pll_mode_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: clock cycles pll_reset is held high per attempt (>=1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 256: consecutive locked cycles required before the mode is declared good (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK+SETTLE cycles per attempt (16-bit, >=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: attempts per request before failure (>=1).
REQ-005 SHALL have port clock  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port mode_req_valid  in  1  new PLL mode request.
REQ-008 SHALL have port mode_req_data  in  8  requested PLL reconfiguration data.
REQ-009 SHALL have port mode_req_ready  out  1  request accepted on valid&ready.
REQ-010 SHALL have port pll_locked  in  1  PLL lock, asynchronous to clock.
REQ-011 SHALL have port pll_reset  out  1  PLL reset, registered.
REQ-012 SHALL have port pll_data  out  8  PLL reconfiguration data, registered.
REQ-013 SHALL have port mode_active  out  8  last mode that completed settling.
REQ-014 SHALL have port video_ok  out  1  PLL locked and settled on mode_active.
REQ-015 SHALL have port error  out  1  last request exhausted retries.
REQ-016 SHALL have port lock_lost  out  1  one-cycle pulse on unexpected lock loss (see REQ-034).

Function
REQ-017 SHALL synchronize pll_locked via two flops (locked_s); all decisions use locked_s only.
REQ-018 SHALL implement states IDLE, RESET_PLL, WAIT_LOCK, SETTLE, FAIL.
REQ-019 SHALL assert mode_req_ready combinationally only in IDLE or FAIL.
REQ-020 On accept (valid&ready at edge N): pll_data<=mode_req_data, retry count<=0, video_ok<=0, error<=0, state<=RESET_PLL, all effective at N+1.
REQ-021 RESET_PLL: pll_reset=1 for exactly RESET_CYCLES cycles, then pll_reset<=0, timeout counter<=0, state<=WAIT_LOCK.
REQ-022 WAIT_LOCK: locked_s=1 -> SETTLE with settle counter<=0; timeout counter increments every cycle in WAIT_LOCK and SETTLE.
REQ-023 SETTLE: locked_s=0 -> back to WAIT_LOCK, settle counter cleared, timeout counter not cleared.
REQ-024 SETTLE: SETTLE_CYCLES consecutive locked_s=1 cycles -> IDLE, video_ok<=1, mode_active<=pll_data.
REQ-025 Timeout counter reaching LOCK_TIMEOUT in WAIT_LOCK/SETTLE -> retry count+1; if new count < MAX_RETRIES -> RESET_PLL, else -> FAIL.
REQ-026 FAIL: error=1, pll_reset=1, video_ok=0; held until a new request is accepted.
REQ-027 mode_req_valid outside IDLE/FAIL SHALL be ignored (not queued); requester holds valid until ready.
REQ-028 pll_data SHALL change only on accept or reset; stable throughout all retries.
REQ-029 Counters SHALL saturate and never wrap; a parameter value of 1 SHALL yield exactly one cycle.

Reset
REQ-030 On reset: state<=RESET_PLL, pll_reset<=1, pll_data<=8'd0, mode_active<=8'd0, video_ok<=0, error<=0, lock_lost<=0, counters<=0, sync flops<=0.
REQ-031 After reset SHALL run an initial sequence for mode 8'd0 exactly as an accepted request, without a handshake.
REQ-032 Reset asserted mid-sequence SHALL abandon it and restart per REQ-030/031; reset has priority over all events.
REQ-033 mode_req_ready SHALL be 0 during reset and until the initial sequence finishes.

Configuration
REQ-034 With PLL_LOCK_MONITOR_EN defined: in IDLE with video_ok=1, locked_s=0 SHALL pulse lock_lost for one cycle, clear video_ok and restart at RESET_PLL with unchanged pll_data and retry count 0; the monitor SHALL have priority over a simultaneous request.
REQ-035 Without PLL_LOCK_MONITOR_EN: lock_lost tied 0; loss of lock in IDLE ignored and video_ok holds.

Verification (RESET_CYCLES=4, SETTLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2)
REQ-036 Reset 3 cycles, pll_locked=1 throughout -> pll_reset high 4 cycles after reset release, video_ok=1 with mode_active=0x00 after sync and settle, ready=1.
REQ-037 Request 0x5A in IDLE -> ready drops next cycle, pll_data=0x5A, pll_reset 4 cycles, video_ok=1 and mode_active=0x5A after lock+8 cycles.
REQ-038 pll_locked held 0 -> two attempts of 4 reset cycles + 32 wait cycles, then FAIL: error=1, ready=1; request 0x11 clears error.
REQ-039 Lock glitch low 1 cycle at settle count 5 -> settle restarts, video_ok only after 8 further consecutive locked cycles.
REQ-040 PLL_LOCK_MONITOR_EN defined, IDLE with video_ok=1, pll_locked drops -> lock_lost one-cycle pulse, video_ok=0, reseq with same pll_data; undefined -> no reaction.
